mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access stage of the RISC-V pipeline, placed between execute and writeback. Takes the instruction word, ALU result and store data from execute. Performs byte/half/word loads and stores against a local data memory, and registers the instruction word, ALU result and load data for writeback. Loads take a configurable number of cycles, during which the stage stalls upstream.

## Interface
- DEPTH, 256: data memory size in 32-bit words (power of two); address index = ALUResult[log2(DEPTH)+1:2], upper bits ignored (wrap-around).
- LOAD_LAT, 2: cycles from load acceptance to out_valid (1..4).
- clk1  input  1  single clock, all state on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  execute presents an instruction this cycle.
- in_IR  input  32  instruction word from execute.
- in_ALUResult  input  32  effective address (loads/stores) or ALU result.
- in_StoreData  input  32  rs2 value for stores.
- stall  output  1  stage busy with a load; upstream must hold in_* and not advance.
- RD_Instr  output  32  registered instruction to writeback.
- ALUResult  output  32  registered ALU result.
- ReadData  output  32  registered, extended load data.
- out_valid  output  1  output registers hold a real instruction.
- misaligned  output  1  registered flag: the instruction in RD_Instr was a misaligned load/store.

## Operation
- Decode on in_IR[6:0]:
  - 0000011 is a load.
  - 0100011 is a store.
  - Anything else is pass-through.
  - funct3 = in_IR[14:12].
- Loads:
  - LB 000 and LH 001 are sign-extended.
  - LW 010 returns the full word.
  - LBU 100 and LHU 101 are zero-extended.
  - The byte lane is selected by addr[1:0]; the half lane by addr[1].
  - Other funct3 values act as LW.
- Stores:
  - SB 000 writes one byte lane from StoreData[7:0].
  - SH 001 writes one half lane from StoreData[15:0].
  - SW 010 writes the full word.
  - Other funct3 values: no write.
  - Unwritten lanes are preserved.
- Misalignment:
  - Half access with addr[0]=1, or word access with addr[1:0]≠0.
  - Effect: no memory write, ReadData=0, misaligned=1.
  - The instruction still passes with out_valid=1.
- FSM states IDLE and WAIT:
  - IDLE with in_valid:
    - Accept the instruction.
    - If it is an aligned load and LOAD_LAT>1: latch IR, address and funct3, clear the counter, go to WAIT.
    - Otherwise: update the outputs at this edge; a store writes memory at this edge.
  - WAIT: stall=1; counter increments each cycle; in_* ignored.
  - When counter = LOAD_LAT−2: read memory at the latched address, load the outputs, go to IDLE.
- IDLE without in_valid (bubble):
  - out_valid=0, RD_Instr=0x00000013 (NOP), ALUResult=0, ReadData=0, misaligned=0.
  - The NOP ensures writeback does not write the register file.
- Pass-through instructions: ReadData=0.
- Memory contents are not affected by reset.

## Timing
- Reset values:
  - state IDLE, stall=0, out_valid=0, RD_Instr=0x00000013, ALUResult=0, ReadData=0, misaligned=0.
- stall = (state==WAIT), driven from state only; it does not depend combinationally on in_*.
- Latency:
  - Non-load, misaligned load, or LOAD_LAT=1: outputs valid 1 cycle after acceptance.
  - Aligned load: outputs valid LOAD_LAT cycles after acceptance; stall is high for LOAD_LAT−1 cycles.
- Stall release: the cycle stall drops, a new in_valid instruction may be accepted (back-to-back issue).
- Store then load:
  - A store accepted at edge N, followed by a load of the same word accepted at edge N+1, returns the stored data (write-before-read).
- Reset asserted in WAIT:
  - Immediate return to IDLE, pending load discarded, outputs go to reset values.
  - No memory write occurs.
- Address wrap: an address ≥ 4·DEPTH aliases modulo 4·DEPTH.

## Test plan
- SW 0xDEADBEEF to addr 0x10, then LW 0x10 (LOAD_LAT=2):
  - stall high exactly 1 cycle.
  - ReadData=0xDEADBEEF, out_valid=1 two cycles after the load is accepted.
- Byte and half extension, with word 0x10 = 0x80F0_7F81:
  - LB 0x10 → 0xFFFFFF81.
  - LBU 0x13 → 0x00000080.
  - LH 0x12 → 0xFFFF80F0.
  - LHU 0x10 → 0x00007F81.
- SB 0xAA to 0x11 over 0x11223344, then LW 0x10 → 0x1122AA44.
- Misalignment:
  - SW to 0x12 leaves memory unchanged and gives misaligned=1, out_valid=1 after 1 cycle.
  - LH 0x11 gives ReadData=0, misaligned=1, no stall.
- ADD (opcode 0110011) with ALUResult 0x5 followed by a bubble:
  - Cycle 1: RD_Instr=ADD, ALUResult=5, ReadData=0.
  - Cycle 2: RD_Instr=0x00000013, out_valid=0.
- Reset asserted during WAIT of an LW (LOAD_LAT=4):
  - Outputs return to reset values asynchronously, stall=0.
  - Memory is unchanged and the next LW returns the correct data.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage: byte/half/word loads and stores against a local data memory,
// with a multi-cycle load path that holds upstream via stall.
module mem_access_stage #(
  parameter int DEPTH    = 256,
  parameter int LOAD_LAT = 2
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_IR,
  input  logic [31:0] in_ALUResult,
  input  logic [31:0] in_StoreData,
  output logic        stall,
  output logic [31:0] RD_Instr,
  output logic [31:0] ALUResult,
  output logic [31:0] ReadData,
  output logic        out_valid,
  output logic        misaligned
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam bit          MULTI    = (LOAD_LAT > 1);
  localparam logic [1:0]  CNT_LAST = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state;
  logic [1:0]    cnt_p0;
  logic [31:0]   ir_p0;
  logic [31:0]   addr_p0;
  logic [31:0]   mem [DEPTH];

  logic          is_load;
  logic          is_store;
  logic          mis;
  logic          st_wr;
  logic          go_wait;
  logic [2:0]    f3;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_p0;

  function automatic logic is_misaligned(input logic ld, input logic st,
                                         input logic [2:0] fn, input logic [1:0] a);
    logic half_acc;
    logic word_acc;
    half_acc = (ld && fn[1:0] == 2'b01) || (st && fn == 3'b001);
    word_acc = (ld && fn[1]) || (st && fn == 3'b010);
    return (half_acc && a[0]) || (word_acc && a != 2'b00);
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] fn,
                                               input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (fn)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] sd,
                                              input logic [2:0] fn, input logic [1:0] a);
    logic [31:0] w;
    w = old;
    case (fn)
      3'b000: begin
        case (a)
          2'd0:    w[7:0]   = sd[7:0];
          2'd1:    w[15:8]  = sd[7:0];
          2'd2:    w[23:16] = sd[7:0];
          default: w[31:24] = sd[7:0];
        endcase
      end
      3'b001: begin
        if (a[1]) w[31:16] = sd[15:0];
        else      w[15:0]  = sd[15:0];
      end
      3'b010:  w = sd;
      default: w = old;
    endcase
    return w;
  endfunction

  assign f3       = in_IR[14:12];
  assign is_load  = (in_IR[6:0] == OP_LOAD);
  assign is_store = (in_IR[6:0] == OP_STORE);
  assign idx      = in_ALUResult[AW+1:2];
  assign idx_p0   = addr_p0[AW+1:2];
  assign mis      = is_misaligned(is_load, is_store, f3, in_ALUResult[1:0]);
  assign go_wait  = MULTI && is_load && !mis;
  assign st_wr    = !rst && (state == IDLE) && in_valid && is_store && !mis &&
                    !f3[2] && (f3[1:0] != 2'b11);
  assign stall    = (state == WAIT);

  // Data memory: never reset; a store lands at its acceptance edge so a load
  // accepted on the following edge already sees it.
  always_ff @(posedge clk1) begin
    if (st_wr)
      mem[idx] <= store_merge(mem[idx], in_StoreData, f3, in_ALUResult[1:0]);
  end

  // Stage p0: pending-load capture for the multi-cycle path
  always_ff @(posedge clk1) begin
    if (state == IDLE && in_valid && go_wait) begin
      ir_p0   <= in_IR;
      addr_p0 <= in_ALUResult;
    end
  end

  // Stage p1: FSM and writeback-facing output registers
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt_p0     <= 2'd0;
      out_valid  <= 1'b0;
      RD_Instr   <= NOP;
      ALUResult  <= 32'd0;
      ReadData   <= 32'd0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (go_wait) begin
              state  <= WAIT;
              cnt_p0 <= 2'd0;
            end else begin
              out_valid  <= 1'b1;
              RD_Instr   <= in_IR;
              ALUResult  <= in_ALUResult;
              ReadData   <= (is_load && !mis) ?
                            load_extract(mem[idx], f3, in_ALUResult[1:0]) : 32'd0;
              misaligned <= mis;
            end
          end else begin
            out_valid  <= 1'b0;
            RD_Instr   <= NOP;
            ALUResult  <= 32'd0;
            ReadData   <= 32'd0;
            misaligned <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_p0 == CNT_LAST) begin
            state      <= IDLE;
            out_valid  <= 1'b1;
            RD_Instr   <= ir_p0;
            ALUResult  <= addr_p0;
            ReadData   <= load_extract(mem[idx_p0], ir_p0[14:12], addr_p0[1:0]);
            misaligned <= 1'b0;
          end else begin
            cnt_p0 <= cnt_p0 + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
